// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed gain mixer.
// Holds the FSM state type, default parameter values and unsigned saturation.
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mixer_state_t;

  localparam int DEF_NUM_CH    = 12;
  localparam int DEF_W         = 8;
  localparam int DEF_GAIN_W    = 4;
  localparam int DEF_GAIN_FRAC = 3;

  // Clamp an unsigned accumulator value to the largest w-bit code.
  function automatic logic [31:0] sat_u(input logic [31:0] acc, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (acc > max_val) ? max_val : acc;
  endfunction

endpackage

// File: rtl/mixer_mac.sv
// Combinational multiply-accumulate shared by all channels of the mixer.
// Each product is floor-shifted by GAIN_FRAC before it is added.
module mixer_mac #(
  parameter int W         = 8,
  parameter int GAIN_W    = 4,
  parameter int GAIN_FRAC = 3,
  parameter int ACC_W     = 16
) (
  input  logic [W-1:0]      sample,
  input  logic [GAIN_W-1:0] gain,
  input  logic              enable,
  input  logic [ACC_W-1:0]  acc_in,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int PROD_W = W + GAIN_W;

  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] scaled;

  always_comb begin
    product = PROD_W'(sample) * PROD_W'(gain);
    scaled  = product >> GAIN_FRAC;
    acc_out = acc_in + (enable ? ACC_W'(scaled) : '0);
  end

endmodule

// File: rtl/gain_mixer_seq.sv
// Sequential gain mixer: one shared MAC walks the channels, one per clock,
// then the saturated sum is published with a one-cycle valid pulse.
module gain_mixer_seq
  import mixer_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int W         = DEF_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_CH*W-1:0]        samples,
  input  logic [NUM_CH*GAIN_W-1:0]   gains,
  input  logic [NUM_CH-1:0]          sample_enable,
  input  logic                       sample_strobe,
  output logic [W-1:0]               sample_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int ACC_W = W + GAIN_W + $clog2(NUM_CH + 1);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mixer_state_t state;
  mixer_state_t state_next;

  logic                     accept;
  logic                     step;
  logic                     finish;
  logic [IDX_W-1:0]         idx;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         acc_next;
  logic [NUM_CH*W-1:0]      samples_sh;
  logic [NUM_CH*GAIN_W-1:0] gains_sh;
  logic [NUM_CH-1:0]        enable_sh;
  logic [W-1:0]             sample_cur;
  logic [GAIN_W-1:0]        gain_cur;
  logic                     enable_cur;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (sample_strobe) begin
          accept     = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        step = 1'b1;
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        finish = 1'b1;
        // A strobe on the publishing edge starts the next mix without an idle gap.
        if (sample_strobe) begin
          accept     = 1'b1;
          state_next = ACCUM;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Shadow copies free the inputs to change as soon as a mix is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      samples_sh <= samples;
      gains_sh   <= gains;
      enable_sh  <= sample_enable;
    end
  end

  always_comb begin
    sample_cur = samples_sh[int'(idx)*W +: W];
    gain_cur   = gains_sh[int'(idx)*GAIN_W +: GAIN_W];
    enable_cur = enable_sh[idx];
  end

  mixer_mac #(
    .W         (W),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac (
    .sample  (sample_cur),
    .gain    (gain_cur),
    .enable  (enable_cur),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc        <= '0;
      idx        <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= finish;
      overrun   <= sample_strobe && (state == ACCUM);
      if (finish) sample_out <= W'(sat_u(32'(acc), W));
      if (accept) begin
        acc <= '0;
        idx <= '0;
      end else if (step) begin
        acc <= acc_next;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gain_mixer_seq.sv
// Self-checking bench for gain_mixer_seq with a plain-arithmetic mix model.
module tb_gain_mixer_seq;

  localparam int NUM_CH    = 12;
  localparam int W         = 8;
  localparam int GAIN_W    = 4;
  localparam int GAIN_FRAC = 3;

  logic                     clk = 1'b0;
  logic                     n_rst = 1'b0;
  logic [NUM_CH*W-1:0]      samples = '0;
  logic [NUM_CH*GAIN_W-1:0] gains = '0;
  logic [NUM_CH-1:0]        sample_enable = '0;
  logic                     sample_strobe = 1'b0;
  logic [W-1:0]             sample_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gain_mixer_seq #(
    .NUM_CH    (NUM_CH),
    .W         (W),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .samples       (samples),
    .gains         (gains),
    .sample_enable (sample_enable),
    .sample_strobe (sample_strobe),
    .sample_out    (sample_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  function automatic int model(input logic [NUM_CH*W-1:0] s,
                               input logic [NUM_CH*GAIN_W-1:0] g,
                               input logic [NUM_CH-1:0] en);
    int sum;
    sum = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (en[k]) sum += (int'(s[k*W +: W]) * int'(g[k*GAIN_W +: GAIN_W])) / (1 << GAIN_FRAC);
    return (sum > 255) ? 255 : sum;
  endfunction

  function automatic logic [NUM_CH*GAIN_W-1:0] all_gain(input int g);
    logic [NUM_CH*GAIN_W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*GAIN_W +: GAIN_W] = GAIN_W'(g);
    return r;
  endfunction

  function automatic logic [NUM_CH*W-1:0] all_smp(input int v);
    logic [NUM_CH*W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*W +: W] = W'(v);
    return r;
  endfunction

  task automatic scramble_inputs();
    logic [63:0] t;
    t = {$urandom, $urandom};
    samples       = {$urandom, $urandom, $urandom};
    gains         = t[47:0];
    sample_enable = 12'($urandom);
  endtask

  // Strobe one mix and watch 18 cycles; lat counts clock edges from accept to out_valid.
  task automatic run_mix(input logic [NUM_CH*W-1:0] s, input logic [NUM_CH*GAIN_W-1:0] g,
                         input logic [NUM_CH-1:0] en, output logic [W-1:0] res,
                         output int lat, output int busy_cnt, output int vcnt);
    @(negedge clk);
    samples = s; gains = g; sample_enable = en; sample_strobe = 1'b1;
    lat = -1; busy_cnt = 0; vcnt = 0; res = '0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sample_strobe = 1'b0;
        scramble_inputs();
      end
      if (busy) busy_cnt++;
      if (out_valid) begin
        vcnt++;
        if (lat < 0) begin
          lat = c - 1;
          res = sample_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (sample_out !== 8'd0) begin n_err++; $display("FAIL reset_sample_out got %0d want 0", sample_out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity();
    logic [W-1:0] res; int lat, bc, vc;
    logic [NUM_CH*W-1:0] s;
    s = '0; s[7:0] = 8'd25;
    run_mix(s, all_gain(8), 12'hFFF, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd25) begin n_err++; $display("FAIL unity_value got %0d want 25", res); end
    n_cmp++; if (lat != 13) begin n_err++; $display("FAIL unity_latency got %0d want 13", lat); end
    n_cmp++; if (bc != 13) begin n_err++; $display("FAIL unity_busy_cycles got %0d want 13", bc); end
    n_cmp++; if (vc != 1) begin n_err++; $display("FAIL unity_valid_count got %0d want 1", vc); end
  endtask

  task automatic test_mask();
    logic [W-1:0] res; int lat, bc, vc;
    logic [NUM_CH*W-1:0] s;
    s = '0; s[15:0] = {8'd25, 8'd25};
    run_mix(s, all_gain(8), 12'h002, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd25) begin n_err++; $display("FAIL mask_ch1 got %0d want 25", res); end
    run_mix(all_smp(25), all_gain(8), 12'h000, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd0 || vc != 1) begin n_err++; $display("FAIL mask_zero got %0d valid %0d want 0 valid 1", res, vc); end
  endtask

  task automatic test_sum_sat();
    logic [W-1:0] res; int lat, bc, vc;
    logic [NUM_CH*W-1:0] s;
    s = '0; s[23:0] = {8'd25, 8'd25, 8'd25};
    run_mix(s, all_gain(8), 12'h007, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd75) begin n_err++; $display("FAIL sum_three got %0d want 75", res); end
    s = '0; s[15:0] = {8'd200, 8'd200};
    run_mix(s, all_gain(8), 12'h003, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd255) begin n_err++; $display("FAIL sat_two got %0d want 255", res); end
    run_mix(all_smp(255), all_gain(15), 12'hFFF, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd255) begin n_err++; $display("FAIL sat_full got %0d want 255", res); end
  endtask

  task automatic test_gain();
    logic [W-1:0] res; int lat, bc, vc;
    logic [NUM_CH*W-1:0] s;
    logic [NUM_CH*GAIN_W-1:0] g;
    int gv [3] = '{4, 15, 0};
    int ev [3] = '{50, 187, 0};
    s = '0; s[7:0] = 8'd100;
    for (int i = 0; i < 3; i++) begin
      g = all_gain(8); g[3:0] = 4'(gv[i]);
      run_mix(s, g, 12'h001, res, lat, bc, vc);
      n_cmp++; if (int'(res) != ev[i]) begin n_err++; $display("FAIL gain_%0d got %0d want %0d", gv[i], res, ev[i]); end
    end
    s = '0; s[15:0] = {8'd7, 8'd7};
    run_mix(s, all_gain(1), 12'h003, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd0) begin n_err++; $display("FAIL gain_floor got %0d want 0", res); end
  endtask

  task automatic test_random();
    logic [W-1:0] res; int lat, bc, vc, exp_v;
    logic [NUM_CH*W-1:0] s;
    logic [NUM_CH*GAIN_W-1:0] g;
    logic [NUM_CH-1:0] en;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        s[k*W +: W] = (i % 2 == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom);
        g[k*GAIN_W +: GAIN_W] = 4'($urandom);
      end
      en = 12'($urandom);
      exp_v = model(s, g, en);
      run_mix(s, g, en, res, lat, bc, vc);
      n_cmp++;
      if (int'(res) != exp_v || lat != 13 || vc != 1) begin
        n_err++;
        $display("FAIL random_%0d got %0d lat %0d valid %0d want %0d lat 13 valid 1", i, res, lat, vc, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_q [$];
    int vcnt, ocnt, last_c, gap_bad;
    logic [NUM_CH*W-1:0] s;
    logic [NUM_CH*GAIN_W-1:0] g;
    logic [NUM_CH-1:0] en;
    vcnt = 0; ocnt = 0; last_c = -1; gap_bad = 0;
    for (int c = 0; c < 58; c++) begin
      @(negedge clk);
      if (overrun) ocnt++;
      if (out_valid) begin
        vcnt++;
        if (last_c >= 0 && c - last_c != 13) gap_bad++;
        last_c = c;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra_valid got %0d want none", sample_out);
        end else begin
          if (int'(sample_out) != exp_q[0]) begin
            n_err++; $display("FAIL b2b_value got %0d want %0d", sample_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (c % 13 == 0 && c < 52) begin
        for (int k = 0; k < NUM_CH; k++) begin
          s[k*W +: W] = 8'($urandom_range(0, 50));
          g[k*GAIN_W +: GAIN_W] = 4'($urandom);
        end
        en = 12'($urandom);
        exp_q.push_back(model(s, g, en));
        samples = s; gains = g; sample_enable = en; sample_strobe = 1'b1;
      end else begin
        sample_strobe = 1'b0;
        scramble_inputs();
      end
    end
    n_cmp++; if (vcnt != 4) begin n_err++; $display("FAIL b2b_valid_count got %0d want 4", vcnt); end
    n_cmp++; if (ocnt != 0 || gap_bad != 0) begin n_err++; $display("FAIL b2b_timing overrun %0d badgaps %0d want 0 0", ocnt, gap_bad); end
  endtask

  task automatic test_overrun();
    int vcnt, ocnt, oc_at, exp_v;
    logic [W-1:0] res;
    logic [NUM_CH*W-1:0] s;
    for (int k = 0; k < NUM_CH; k++) s[k*W +: W] = 8'($urandom_range(0, 30));
    exp_v = model(s, all_gain(8), 12'hFFF);
    vcnt = 0; ocnt = 0; oc_at = -1; res = '0;
    @(negedge clk);
    samples = s; gains = all_gain(8); sample_enable = 12'hFFF; sample_strobe = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      sample_strobe = (c == 5);
      if (c == 5) begin samples = all_smp(200); gains = all_gain(15); end
      if (overrun) begin ocnt++; oc_at = c; end
      if (out_valid) begin vcnt++; res = sample_out; end
    end
    n_cmp++; if (ocnt != 1 || oc_at != 6) begin n_err++; $display("FAIL overrun_pulse got %0d pulses at %0d want 1 at 6", ocnt, oc_at); end
    n_cmp++; if (vcnt != 1 || int'(res) != exp_v) begin n_err++; $display("FAIL overrun_result got %0d valid %0d want %0d valid 1", res, vcnt, exp_v); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL overrun_idle busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res; int lat, bc, vc, exp_v;
    logic [NUM_CH*W-1:0] s;
    s = '0; s[7:0] = 8'd100;
    run_mix(s, all_gain(8), 12'h001, res, lat, bc, vc);
    n_cmp++; if (res !== 8'd100) begin n_err++; $display("FAIL prereset_value got %0d want 100", res); end
    @(negedge clk);
    samples = all_smp(20); gains = all_gain(8); sample_enable = 12'hFFF; sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if (sample_out !== 8'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs got out %0d busy %b valid %b want 0 0 0", sample_out, busy, out_valid);
    end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    vc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (out_valid) vc++;
    end
    n_cmp++; if (vc != 0) begin n_err++; $display("FAIL midreset_no_valid got %0d want 0", vc); end
    for (int k = 0; k < NUM_CH; k++) s[k*W +: W] = 8'($urandom_range(0, 20));
    exp_v = model(s, all_gain(8), 12'h5A5);
    run_mix(s, all_gain(8), 12'h5A5, res, lat, bc, vc);
    n_cmp++; if (int'(res) != exp_v || vc != 1) begin n_err++; $display("FAIL postreset_mix got %0d want %0d", res, exp_v); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unity();
    test_mask();
    test_sum_sat();
    test_gain();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
